// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op encodings, immediate formats
// and the ID/EX control word layout.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } aluop_e;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_we;
    logic [2:0] aluop;
    logic       asrc;
    logic       bsrc;
    logic       sub;
    logic       sra;
    logic       shdir;
    logic       jalr;
    logic       jal;
    logic       link;
    logic       branch;
    logic [2:0] brfunct;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] mem_size;
    logic       illegal;
  } id_ex_t;

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch -> decode -> execute handshake bundle; slave is the decode stage view.
interface rv_decode_stage_if;
  import rv_pkg::*;

  logic            if_valid;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1_addr;
  logic [4:0]      ex_rs2_addr;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_we;
  logic [2:0]      ex_aluop;
  logic            ex_asrc;
  logic            ex_bsrc;
  logic            ex_sub;
  logic            ex_sra;
  logic            ex_shdir;
  logic            ex_jalr;
  logic            ex_jal;
  logic            ex_link;
  logic            ex_branch;
  logic [2:0]      ex_brfunct;
  logic            ex_mem_rd;
  logic            ex_mem_wr;
  logic [2:0]      ex_mem_size;
  logic            ex_illegal;

  modport slave (
    input  if_valid, if_instr, if_pc, flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_imm, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_rd_we, ex_aluop, ex_asrc, ex_bsrc, ex_sub, ex_sra,
           ex_shdir, ex_jalr, ex_jal, ex_link, ex_branch, ex_brfunct,
           ex_mem_rd, ex_mem_wr, ex_mem_size, ex_illegal
  );

  modport master (
    output if_valid, if_instr, if_pc, flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_imm, ex_rs1_addr, ex_rs2_addr,
           ex_rd_addr, ex_rd_we, ex_aluop, ex_asrc, ex_bsrc, ex_sub, ex_sra,
           ex_shdir, ex_jalr, ex_jal, ex_link, ex_branch, ex_brfunct,
           ex_mem_rd, ex_mem_wr, ex_mem_size, ex_illegal
  );
endinterface

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator; shift-immediates yield the bare shamt.
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:     imm = {instr[31:12], 12'b0};
      IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SHAMT: imm = {27'b0, instr[24:20]};
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: instruction decode, immediate generation and the ID/EX
// pipeline register with valid/ready handshake and flush.
module rv_decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst_n,
  rv_decode_stage_if.slave  bus
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            has_rd;
  logic            bad;
  imm_fmt_e        fmt;
  id_ex_t          dec;
  logic [31:0]     imm;

  logic            valid_q;
  id_ex_t          ctrl_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;

  assign opc = bus.if_instr[6:0];
  assign f3  = bus.if_instr[14:12];
  assign f7  = bus.if_instr[31:25];

  rv_imm_gen u_imm_gen (
    .instr (bus.if_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  always_comb begin
    dec     = '0;
    dec.sub = 1'b1;
    dec.rs1 = bus.if_instr[19:15];
    has_rd  = 1'b0;
    bad     = 1'b0;
    fmt     = IMM_NONE;
    case (opcode_e'(opc))
      OPC_OP: begin
        has_rd    = 1'b1;
        dec.rs2   = bus.if_instr[24:20];
        dec.aluop = f3;
        dec.shdir = (f3 == 3'b001);
        if (f3 == 3'b000) dec.sub = ~f7[5];
        if (f3 == 3'b101) dec.sra = f7[5];
        // funct7 0x20 is only meaningful for SUB and SRA
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))) bad = 1'b1;
      end
      OPC_OP_IMM: begin
        has_rd    = 1'b1;
        dec.aluop = f3;
        dec.bsrc  = 1'b1;
        fmt       = IMM_I;
        if (f3 == 3'b001) begin
          fmt       = IMM_SHAMT;
          dec.shdir = 1'b1;
          if (f7 != 7'h00) bad = 1'b1;
        end
        if (f3 == 3'b101) begin
          fmt     = IMM_SHAMT;
          dec.sra = f7[5];
          if (f7 != 7'h00 && f7 != 7'h20) bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        has_rd       = 1'b1;
        dec.aluop    = ALU_ADD;
        dec.bsrc     = 1'b1;
        dec.mem_rd   = 1'b1;
        dec.mem_size = f3;
        fmt          = IMM_I;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) bad = 1'b1;
      end
      OPC_STORE: begin
        dec.rs2      = bus.if_instr[24:20];
        dec.aluop    = ALU_ADD;
        dec.bsrc     = 1'b1;
        dec.mem_wr   = 1'b1;
        dec.mem_size = f3;
        fmt          = IMM_S;
        if (f3 > 3'b010) bad = 1'b1;
      end
      OPC_LUI: begin
        has_rd   = 1'b1;
        dec.rs1  = '0;
        dec.bsrc = 1'b1;
        fmt      = IMM_U;
      end
      OPC_AUIPC: begin
        has_rd   = 1'b1;
        dec.asrc = 1'b1;
        dec.bsrc = 1'b1;
        fmt      = IMM_U;
      end
      OPC_JAL: begin
        has_rd   = 1'b1;
        dec.rs1  = '0;
        dec.jal  = 1'b1;
        dec.link = 1'b1;
        dec.asrc = 1'b1;
        fmt      = IMM_J;
      end
      OPC_JALR: begin
        has_rd   = 1'b1;
        dec.jalr = 1'b1;
        dec.link = 1'b1;
        dec.asrc = 1'b1;
        fmt      = IMM_I;
        if (f3 != 3'b000) bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs2     = bus.if_instr[24:20];
        dec.branch  = 1'b1;
        dec.brfunct = f3;
        dec.sub     = 1'b0;
        fmt         = IMM_B;
        if (f3[2:1] == 2'b01) bad = 1'b1;
      end
      OPC_MISC_MEM: ;
      // every legal opcode ends in 2'b11, so instr[1:0]!=11 lands here too
      default: bad = 1'b1;
    endcase
    dec.rd    = has_rd ? bus.if_instr[11:7] : 5'd0;
    dec.rd_we = has_rd && (bus.if_instr[11:7] != 5'd0);
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
      fmt         = IMM_NONE;
    end
  end

  assign bus.id_ready = ~valid_q | bus.ex_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
    end else begin
      if (bus.id_ready) begin
        valid_q <= bus.if_valid;
        if (bus.if_valid) begin
          ctrl_q <= dec;
          pc_q   <= bus.if_pc;
          imm_q  <= imm;
        end
      end
      if (bus.flush) valid_q <= 1'b0;
    end
  end

  assign bus.ex_valid    = valid_q;
  assign bus.ex_pc       = pc_q;
  assign bus.ex_imm      = imm_q;
  assign bus.ex_rs1_addr = ctrl_q.rs1;
  assign bus.ex_rs2_addr = ctrl_q.rs2;
  assign bus.ex_rd_addr  = ctrl_q.rd;
  assign bus.ex_rd_we    = ctrl_q.rd_we;
  assign bus.ex_aluop    = ctrl_q.aluop;
  assign bus.ex_asrc     = ctrl_q.asrc;
  assign bus.ex_bsrc     = ctrl_q.bsrc;
  assign bus.ex_sub      = ctrl_q.sub;
  assign bus.ex_sra      = ctrl_q.sra;
  assign bus.ex_shdir    = ctrl_q.shdir;
  assign bus.ex_jalr     = ctrl_q.jalr;
  assign bus.ex_jal      = ctrl_q.jal;
  assign bus.ex_link     = ctrl_q.link;
  assign bus.ex_branch   = ctrl_q.branch;
  assign bus.ex_brfunct  = ctrl_q.brfunct;
  assign bus.ex_mem_rd   = ctrl_q.mem_rd;
  assign bus.ex_mem_wr   = ctrl_q.mem_wr;
  assign bus.ex_mem_size = ctrl_q.mem_size;
  assign bus.ex_illegal  = ctrl_q.illegal;

endmodule
